down_counter_ctrl: RTL
======================

# down_counter_ctrl

Sequencing controller for the team's N-bit down counter. It accepts a start request with a load value and prescale setting, then counts down to zero in prescaled steps. It supports pause and abort, and flags terminal count with a single-cycle pulse. It sits between a software/FSM requester and the count datapath, and owns the counter register.

## Interface
- N, 10, counter width in bits
- PRESCALE_W, 4, prescale field width
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- start_req  input  1  start request; requester holds it high until start_ack
- load_val  input  N  start value, sampled when the request is accepted
- prescale  input  PRESCALE_W  clocks per decrement minus 1, sampled when the request is accepted
- periodic  input  1  auto-reload select, sampled when the request is accepted (ignored without macro)
- pause  input  1  level; freezes counting while high
- abort  input  1  returns controller to IDLE
- start_ack  output  1  one-cycle registered pulse: request accepted
- count  output  N  current counter value
- busy  output  1  high in RUN or PAUSED
- done  output  1  one-cycle registered pulse at terminal count

## Operation
- FSM states, encoded 2 bits: IDLE=0, RUN=1, PAUSED=2, DONE=3.
- Reset (reset=0, async) values:
  - state=IDLE
  - count=0, prescale counter=0
  - start_ack=0, done=0, busy=0
- Accept rule: in IDLE or DONE, start_req=1 and abort=0. On that edge:
  - latch load_val, prescale and periodic
  - count<=load_val, pre<=prescale, start_ack<=1
  - state<=RUN
  - Exception: load_val=0 sets state<=DONE and done<=1 (count stays 0).
- In RUN with pause=0, pre decrements each cycle. When pre=0:
  - pre<=latched prescale, count<=count-1
  - If count was 1: done<=1.
    - Non-periodic: state<=DONE.
    - Periodic: count<=latched load, stay in RUN.
- Pause:
  - RUN with pause=1: state<=PAUSED on that edge; count and pre are not modified.
  - PAUSED with pause=0: state<=RUN.
- Abort has highest priority, from any state: state<=IDLE, count<=0, pre<=0, no done, no start_ack.
- DONE holds count=0, busy=0 until the next accepted request or abort.
- Requests while busy (RUN/PAUSED) are ignored; no ack is issued.
- Arithmetic: count never decrements below 0. No wrap-around except the periodic reload.

## Timing
- start_ack goes high the cycle after the accepting edge, for exactly one cycle. The requester must drop start_req by the following edge.
- Non-paused latency: done is high L*(P+1) cycles after the edge that raises start_ack (L=load_val, P=prescale).
- Every paused cycle adds one cycle to that latency.
- busy rises together with start_ack and falls together with entry to DONE or IDLE.
- done and the count=0 update land on the same edge.
- A pause or abort sampled on a terminal-tick edge wins: no decrement, no done.
- Reset asserted mid-operation clears all outputs immediately, independent of clk.

## Configuration
- DOWN_COUNTER_CTRL_AUTO_RELOAD_EN
  - Defined: periodic is honoured. At terminal count the counter reloads the latched load_val, pulses done, and stays in RUN until abort.
  - Undefined: periodic is not sampled, and every run ends in DONE.

## Test plan
- Reset while in RUN with count=7 -> count=0, busy=0, state=IDLE immediately. No done or start_ack follows.
- load_val=5, prescale=0 -> count 5,4,3,2,1,0 on successive edges; done pulses 5 cycles after start_ack; state=DONE, busy=0.
- load_val=3, prescale=2 -> count steps every 3 cycles; done 9 cycles after start_ack. load_val=0 -> done with start_ack edge, busy stays 0.
- load_val=4, prescale=0, pause high 4 cycles after the first decrement -> count frozen at 3, state=PAUSED; done at cycle 8 after start_ack.
- abort at count=2 -> IDLE, count=0, no done. Abort and start_req in the same cycle -> no start_ack. start_req while busy -> ignored.
- Macro defined, periodic=1, load_val=2, prescale=0 -> count 2,1,2,1,...; done every 2 cycles; busy stays 1 until abort. Macro undefined, same stimulus -> single done, state=DONE.

Source files
------------

// File: rtl/down_counter_ctrl_if.sv
// down_counter_ctrl_if: request/status bundle between a requester and the down-counter controller.
// Latency: none, plain wires.
// Backpressure: start_req is held by the master until the slave returns start_ack.
interface down_counter_ctrl_if #(
    parameter int N          = 10,
    parameter int PRESCALE_W = 4
);
    logic                  start_req;
    logic [N-1:0]          load_val;
    logic [PRESCALE_W-1:0] prescale;
    logic                  periodic;
    logic                  pause;
    logic                  abort;
    logic                  start_ack;
    logic [N-1:0]          count;
    logic                  busy;
    logic                  done;

    // Requester side: issues commands, watches status.
    modport master (
        output start_req, load_val, prescale, periodic, pause, abort,
        input  start_ack, count, busy, done
    );

    // Controller side: consumes commands, drives status.
    modport slave (
        input  start_req, load_val, prescale, periodic, pause, abort,
        output start_ack, count, busy, done
    );
endinterface

// File: rtl/down_counter_ctrl.sv
// down_counter_ctrl: sequencing controller that owns an N-bit down counter with prescale, pause and abort.
// Latency: start_ack one cycle after acceptance; done L*(P+1) cycles after start_ack, plus one per paused cycle.
// Backpressure: start_req is held until start_ack; requests arriving while busy are dropped with no ack.
// Optional feature macro: DOWN_COUNTER_CTRL_AUTO_RELOAD_EN enables periodic auto-reload at terminal count.
module down_counter_ctrl #(
    parameter int N          = 10,
    parameter int PRESCALE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    down_counter_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [N-1:0]          CNT_ONE = {{(N-1){1'b0}}, 1'b1};
    localparam logic [PRESCALE_W-1:0] PRE_ONE = {{(PRESCALE_W-1){1'b0}}, 1'b1};

    state_t                state_q,    state_d;
    logic [N-1:0]          count_q,    count_d;
    logic [PRESCALE_W-1:0] pre_q,      pre_d;
    logic [PRESCALE_W-1:0] lat_pre_q,  lat_pre_d;
    logic [N-1:0]          lat_load_q, lat_load_d;
    logic                  ack_q,      ack_d;
    logic                  done_q,     done_d;
    logic                  periodic_act;

`ifdef DOWN_COUNTER_CTRL_AUTO_RELOAD_EN
    logic                  lat_per_q,  lat_per_d;

    // Periodic-mode flag captured with the accepted request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lat_per_q <= 1'b0;
        end else begin
            lat_per_q <= lat_per_d;
        end
    end

    assign periodic_act = lat_per_q;
`else
    assign periodic_act = 1'b0;
`endif

    // State and datapath registers; reset clears every visible output at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            count_q    <= '0;
            pre_q      <= '0;
            lat_pre_q  <= '0;
            lat_load_q <= '0;
            ack_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            pre_q      <= pre_d;
            lat_pre_q  <= lat_pre_d;
            lat_load_q <= lat_load_d;
            ack_q      <= ack_d;
            done_q     <= done_d;
        end
    end

    // Next-state and next-datapath: abort first, then accept, then pause, then prescaled ticking.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        pre_d      = pre_q;
        lat_pre_d  = lat_pre_q;
        lat_load_d = lat_load_q;
        ack_d      = 1'b0;
        done_d     = 1'b0;
`ifdef DOWN_COUNTER_CTRL_AUTO_RELOAD_EN
        lat_per_d  = lat_per_q;
`endif

        if (bus.abort) begin
            // Abort beats everything, including a terminal tick on the same edge.
            state_d = IDLE;
            count_d = '0;
            pre_d   = '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (bus.start_req) begin
                        lat_load_d = bus.load_val;
                        lat_pre_d  = bus.prescale;
`ifdef DOWN_COUNTER_CTRL_AUTO_RELOAD_EN
                        lat_per_d  = bus.periodic;
`endif
                        count_d    = bus.load_val;
                        pre_d      = bus.prescale;
                        ack_d      = 1'b1;
                        if (bus.load_val == '0) begin
                            // Nothing to count: terminal immediately, never busy.
                            state_d = DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = RUN;
                        end
                    end
                end

                RUN, PAUSED: begin
                    if (bus.pause) begin
                        // Freeze: count and prescaler untouched, even on a terminal tick.
                        state_d = PAUSED;
                    end else begin
                        // The resume edge ticks like a running edge, so each paused
                        // cycle costs exactly one cycle of latency.
                        state_d = RUN;
                        if (pre_q != '0) begin
                            pre_d = pre_q - PRE_ONE;
                        end else begin
                            pre_d = lat_pre_q;
                            if (count_q == CNT_ONE) begin
                                done_d = 1'b1;
                                if (periodic_act) begin
                                    count_d = lat_load_q;
                                end else begin
                                    count_d = '0;
                                    state_d = DONE;
                                end
                            end else if (count_q != '0) begin
                                count_d = count_q - CNT_ONE;
                            end
                        end
                    end
                end

                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign bus.start_ack = ack_q;
    assign bus.done      = done_q;
    assign bus.count     = count_q;
    assign bus.busy      = (state_q == RUN) || (state_q == PAUSED);

endmodule
